// File: rtl/fe_capture_pkg.sv
// Shared types and constants for the multi-channel front-end capture engine.
// FIFO command codes mirror defines_pw.v so downstream decode stays unchanged.
package fe_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [1:0] FE_FIFO_CMD_DATA = 2'd1;
    localparam logic [1:0] FE_FIFO_CMD_TIME = 2'd2;

    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fe_capture_mc_arb.sv
// Oldest-first arbiter: picks the pending channel with the smallest delta to
// last_stamp; the scan starts after the last grant so ties rotate round-robin.
module fe_capture_mc_arb
    import fe_capture_pkg::*;
#(
    parameter int pCHANNELS             = 4,
    parameter int pTIMESTAMP_FULL_WIDTH = 16
) (
    input  logic [pCHANNELS-1:0]                       i_pending,
    input  logic [pCHANNELS*pTIMESTAMP_FULL_WIDTH-1:0] i_stamps,
    input  logic [pTIMESTAMP_FULL_WIDTH-1:0]           i_last_stamp,
    input  logic [chan_w(pCHANNELS)-1:0]               i_last_grant,
    output logic                                       o_valid,
    output logic [chan_w(pCHANNELS)-1:0]               o_chan,
    output logic [pTIMESTAMP_FULL_WIDTH-1:0]           o_delta
);
    localparam int CW = chan_w(pCHANNELS);
    localparam int TW = pTIMESTAMP_FULL_WIDTH;

    logic [CW-1:0] w_idx;
    logic [TW-1:0] w_delta;

    // Strict less-than keeps the first candidate in rotation order on a tie.
    always_comb begin
        o_valid = 1'b0;
        o_chan  = '0;
        o_delta = '0;
        w_idx   = '0;
        w_delta = '0;
        for (int off = 1; off <= pCHANNELS; off++) begin
            w_idx   = CW'((int'(i_last_grant) + off) % pCHANNELS);
            w_delta = i_stamps[w_idx*TW +: TW] - i_last_stamp;
            if (i_pending[w_idx] && (!o_valid || (w_delta < o_delta))) begin
                o_valid = 1'b1;
                o_chan  = w_idx;
                o_delta = w_delta;
            end
        end
    end

endmodule

// File: rtl/fe_capture_mc.sv
// Multi-channel capture engine: per-channel pending slots merged into one
// delta-timestamped FIFO write stream. Optional FE_CAPTURE_MC_DROP_COUNT_EN adds O_drop_count.
module fe_capture_mc
    import fe_capture_pkg::*;
#(
    parameter int pCHANNELS              = 4,
    parameter int pDATA_WIDTH            = 8,
    parameter int pTIMESTAMP_FULL_WIDTH  = 16,
    parameter int pTIMESTAMP_SHORT_WIDTH = 3,
    parameter int pCAPTURE_LEN_WIDTH     = 24
) (
    input  logic                                 fe_clk,
    input  logic                                 reset_n,
    input  logic [pCHANNELS-1:0]                 I_event,
    input  logic [pCHANNELS*pDATA_WIDTH-1:0]     I_data,
    input  logic [pCHANNELS-1:0]                 I_chan_en,
    input  logic                                 I_arm,
    input  logic                                 I_capture_enable,
    input  logic [pCAPTURE_LEN_WIDTH-1:0]        I_capture_len,
    input  logic [pTIMESTAMP_SHORT_WIDTH-1:0]    I_max_short_timestamp,
    input  logic                                 I_timestamps_disable,
    input  logic                                 I_fifo_full,
    output logic                                 O_fifo_wr,
    output logic [1:0]                           O_fifo_command,
    output logic [chan_w(pCHANNELS)-1:0]         O_fifo_chan,
    output logic [pDATA_WIDTH-1:0]               O_fifo_data,
    output logic [pTIMESTAMP_FULL_WIDTH-1:0]     O_fifo_time,
    output logic                                 O_capturing,
    output logic                                 O_capture_done,
    output logic                                 O_overflow
`ifdef FE_CAPTURE_MC_DROP_COUNT_EN
    ,
    output logic [15:0]                          O_drop_count
`endif
);
    localparam int CW = chan_w(pCHANNELS);
    localparam int DW = pDATA_WIDTH;
    localparam int TW = pTIMESTAMP_FULL_WIDTH;
    localparam logic [TW-1:0] KA_DELTA = {{(TW-1){1'b1}}, 1'b0};

    state_t                      r_state, w_next;
    logic                        r_arm_d;
    logic [TW-1:0]               r_abs_ctr, r_last_stamp;
    logic [pCAPTURE_LEN_WIDTH-1:0] r_pkt_cnt;
    logic [pCHANNELS-1:0]        r_pend;
    logic [pCHANNELS*DW-1:0]     r_pend_data;
    logic [pCHANNELS*TW-1:0]     r_pend_stamp;
    logic [CW-1:0]               r_last_grant, r_hold_ch;
    logic                        r_hold;

    logic                        w_arm_go, w_capt, w_exit, w_limit;
    logic [pCHANNELS-1:0]        w_accept, w_drop, w_clr;
    logic                        w_arb_vld;
    logic [CW-1:0]               w_arb_chan;
    logic [TW-1:0]               w_arb_delta, w_ka_delta, w_max_short, w_last_val;
    logic                        w_wr, w_grant, w_hold_set, w_hold_clr, w_last_upd;
    logic [1:0]                  w_cmd;
    logic [CW-1:0]               w_chan;
    logic [DW-1:0]               w_data;
    logic [TW-1:0]               w_time;

    assign w_arm_go    = I_arm && !r_arm_d && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_capt      = (r_state == ST_CAPTURE);
    assign w_exit      = w_capt && (w_next != ST_CAPTURE);
    assign w_limit     = (I_capture_len != '0) && (r_pkt_cnt >= I_capture_len);
    assign w_accept    = w_capt ? (I_event & I_chan_en & ~r_pend) : '0;
    assign w_drop      = w_capt ? (I_event & I_chan_en & r_pend) : '0;
    assign w_ka_delta  = r_abs_ctr - r_last_stamp;
    assign w_max_short = TW'(I_max_short_timestamp);

    always_ff @(posedge fe_clk) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_arm_go) w_next = ST_ARMED;
            ST_ARMED:   if (I_capture_enable) w_next = ST_CAPTURE;
            ST_CAPTURE: if (!I_capture_enable || (w_limit && !r_hold)) w_next = ST_DONE;
            ST_DONE:    if (w_arm_go) w_next = ST_ARMED;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        O_capturing    = (r_state == ST_CAPTURE);
        O_capture_done = (r_state == ST_DONE);
    end

    fe_capture_mc_arb #(
        .pCHANNELS             (pCHANNELS),
        .pTIMESTAMP_FULL_WIDTH (pTIMESTAMP_FULL_WIDTH)
    ) u_arb (
        .i_pending    (r_pend),
        .i_stamps     (r_pend_stamp),
        .i_last_stamp (r_last_stamp),
        .i_last_grant (r_last_grant),
        .o_valid      (w_arb_vld),
        .o_chan       (w_arb_chan),
        .o_delta      (w_arb_delta)
    );

    // A held TIME/DATA pair finishes before any new grant; the limit only blocks new grants.
    always_comb begin
        w_wr       = 1'b0;
        w_cmd      = '0;
        w_chan     = '0;
        w_data     = '0;
        w_time     = '0;
        w_clr      = '0;
        w_grant    = 1'b0;
        w_hold_set = 1'b0;
        w_hold_clr = 1'b0;
        w_last_upd = 1'b0;
        w_last_val = r_last_stamp;
        if (w_capt && I_capture_enable && !I_fifo_full) begin
            if (r_hold) begin
                w_wr            = 1'b1;
                w_cmd           = FE_FIFO_CMD_DATA;
                w_chan          = r_hold_ch;
                w_data          = r_pend_data[r_hold_ch*DW +: DW];
                w_clr[r_hold_ch] = 1'b1;
                w_hold_clr      = 1'b1;
            end else if (!w_limit && w_arb_vld) begin
                w_wr       = 1'b1;
                w_grant    = 1'b1;
                w_last_upd = 1'b1;
                w_last_val = r_pend_stamp[w_arb_chan*TW +: TW];
                if (I_timestamps_disable || (w_arb_delta <= w_max_short)) begin
                    w_cmd             = FE_FIFO_CMD_DATA;
                    w_chan            = w_arb_chan;
                    w_data            = r_pend_data[w_arb_chan*DW +: DW];
                    w_time            = I_timestamps_disable ? '0 : w_arb_delta;
                    w_clr[w_arb_chan] = 1'b1;
                end else begin
                    w_cmd      = FE_FIFO_CMD_TIME;
                    w_time     = w_arb_delta;
                    w_hold_set = 1'b1;
                end
            end else if (!w_limit && (r_pend == '0) && !I_timestamps_disable &&
                         (w_ka_delta == KA_DELTA)) begin
                w_wr       = 1'b1;
                w_cmd      = FE_FIFO_CMD_TIME;
                w_time     = w_ka_delta;
                w_last_upd = 1'b1;
                w_last_val = r_abs_ctr;
            end
        end
    end

    // ---- control registers ----
    always_ff @(posedge fe_clk) begin
        if (!reset_n) begin
            r_arm_d      <= 1'b0;
            r_abs_ctr    <= '0;
            r_last_stamp <= '0;
            r_pkt_cnt    <= '0;
            r_pend       <= '0;
            r_last_grant <= CW'(pCHANNELS - 1);
            r_hold       <= 1'b0;
            r_hold_ch    <= '0;
            O_overflow   <= 1'b0;
        end else begin
            r_arm_d <= I_arm;
            if (w_arm_go) begin
                r_abs_ctr    <= '0;
                r_last_stamp <= '0;
                r_pkt_cnt    <= '0;
                r_last_grant <= CW'(pCHANNELS - 1);
                O_overflow   <= 1'b0;
            end else begin
                if (w_capt)     r_abs_ctr    <= r_abs_ctr + 1'b1;
                if (w_last_upd) r_last_stamp <= w_last_val;
                if (w_wr)       r_pkt_cnt    <= r_pkt_cnt + 1'b1;
                if (w_grant)    r_last_grant <= w_arb_chan;
                if (|w_drop)    O_overflow   <= 1'b1;
            end
            if (!w_capt || w_exit) begin
                r_pend <= '0;
                r_hold <= 1'b0;
            end else begin
                r_pend <= (r_pend & ~w_clr) | w_accept;
                if (w_hold_set) begin
                    r_hold    <= 1'b1;
                    r_hold_ch <= w_arb_chan;
                end else if (w_hold_clr) begin
                    r_hold <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge fe_clk) begin
        for (int c = 0; c < pCHANNELS; c++) begin
            if (w_accept[c]) begin
                r_pend_data[c*DW +: DW]  <= I_data[c*DW +: DW];
                r_pend_stamp[c*TW +: TW] <= r_abs_ctr;
            end
        end
    end

    // ---- output register stage ----
    always_ff @(posedge fe_clk) begin
        if (!reset_n) begin
            O_fifo_wr      <= 1'b0;
            O_fifo_command <= '0;
            O_fifo_chan    <= '0;
            O_fifo_data    <= '0;
            O_fifo_time    <= '0;
        end else begin
            O_fifo_wr      <= w_wr;
            O_fifo_command <= w_cmd;
            O_fifo_chan    <= w_chan;
            O_fifo_data    <= w_data;
            O_fifo_time    <= w_time;
        end
    end

`ifdef FE_CAPTURE_MC_DROP_COUNT_EN
    logic [4:0] w_drop_n;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [4:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {12'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    always_comb begin
        w_drop_n = '0;
        for (int c = 0; c < pCHANNELS; c++) w_drop_n = w_drop_n + {4'd0, w_drop[c]};
    end

    always_ff @(posedge fe_clk) begin
        if (!reset_n)      O_drop_count <= '0;
        else if (w_arm_go) O_drop_count <= '0;
        else               O_drop_count <= sat_add16(O_drop_count, w_drop_n);
    end
`endif

endmodule
